// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: hardware clear after reset, byte-serial program load, registered fetch.
// Fetch latency 1 cycle (instr/instr_valid registered); one word per cycle sustained in RUN.
// fetch_ready=0 outside RUN; ld_ready=1 only in LOAD, ld_valid=0 stalls the load indefinitely.
module instr_mem_loadable #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               load_start,
  input  logic [ADDR_W:0]    load_len,
  input  logic               ld_valid,
  input  logic [7:0]         ld_byte,
  output logic               ld_ready,
  output logic               ld_done,
  output logic               load_err,
  output logic               busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BPW   = INSTR_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [ADDR_W:0]    DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]    ONE_WORD  = (ADDR_W+1)'(1);
  localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(BPW - 1);
  localparam logic [ADDR_W-1:0]  CLR_LAST  = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_t;

  state_t state;
  state_t state_nxt;

  logic [INSTR_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0]  clr_ptr;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]   byte_cnt;
  logic [ADDR_W:0]    words_left;
  logic [INSTR_W-1:0] word_asm;
  logic [INSTR_W-1:0] word_next;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               fetch_go;
  logic               byte_go;
  logic               word_done;
  logic               load_go;
  logic               load_reject;
  logic               load_empty;

  // Incoming byte lands in the low byte; earlier bytes move up, so the first byte ends in the MSBs.
  assign word_next = (word_asm << 8) | INSTR_W'(ld_byte);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  // Next-state, handshake outputs and the single write port select.
  always_comb begin
    state_nxt   = state;
    fetch_ready = 1'b0;
    ld_ready    = 1'b0;
    busy        = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = clr_ptr;
    mem_wdata   = '0;
    fetch_go    = 1'b0;
    byte_go     = 1'b0;
    word_done   = 1'b0;
    load_go     = 1'b0;
    load_reject = 1'b0;
    load_empty  = 1'b0;
    case (state)
      S_CLEAR: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (clr_ptr == CLR_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        fetch_ready = 1'b1;
        fetch_go    = fetch_req;
        if (load_start) begin
          if (load_len > DEPTH_W) begin
            load_reject = 1'b1;
          end else if (load_len == '0) begin
            load_empty = 1'b1;
          end else begin
            load_go   = 1'b1;
            state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        busy     = 1'b1;
        ld_ready = 1'b1;
        if (ld_valid) begin
          byte_go = 1'b1;
          if (byte_cnt == LAST_BYTE) begin
            mem_we    = 1'b1;
            mem_waddr = wr_ptr;
            mem_wdata = word_next;
            word_done = 1'b1;
            if (words_left == ONE_WORD) state_nxt = S_RUN;
          end
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Memory write port; no write is performed on a reset edge.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  // Registered read port; instr holds its value between accepted fetches.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= fetch_go;
      if (fetch_go) instr <= mem[fetch_addr];
    end
  end

  // Clear pointer, load bookkeeping and status pulses; reset drops any partial load.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr    <= '0;
      wr_ptr     <= '0;
      byte_cnt   <= '0;
      words_left <= '0;
      word_asm   <= '0;
      ld_done    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      ld_done  <= load_empty || (word_done && words_left == ONE_WORD);
      load_err <= load_reject;
      if (state == S_CLEAR) clr_ptr <= clr_ptr + ADDR_W'(1);
      if (load_go) begin
        wr_ptr     <= '0;
        byte_cnt   <= '0;
        words_left <= load_len;
      end
      if (byte_go) begin
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt   <= '0;
          wr_ptr     <= wr_ptr + ADDR_W'(1);
          words_left <= words_left - ONE_WORD;
        end else begin
          byte_cnt <= byte_cnt + CNT_W'(1);
          word_asm <= word_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: directed steps plus random loads/fetches against an array model.
// Outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Model is a plain word array updated from the byte stream of each completed load.
module tb_instr_mem_loadable;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_ready;
  logic [15:0] instr;
  logic        instr_valid;
  logic        load_start;
  logic [8:0]  load_len;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic        ld_done;
  logic        load_err;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [15:0] model [256];
  logic [15:0] exp_instr;
  logic [7:0]  byte_q [$];
  logic [7:0]  addr_q [$];

  instr_mem_loadable #(.INSTR_W(16), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr(instr), .instr_valid(instr_valid),
    .load_start(load_start), .load_len(load_len),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready),
    .ld_done(ld_done), .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Back-to-back fetches of addr_q, one per cycle, then an idle cycle.
  task automatic fetch_burst(input string tag);
    for (int i = 0; i < addr_q.size(); i++) begin
      fetch_req  = 1'b1;
      fetch_addr = addr_q[i];
      tick();
      exp_instr = model[addr_q[i]];
      chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
      chk({tag, "_instr"}, 32'(instr), 32'(exp_instr));
    end
    fetch_req = 1'b0;
    tick();
    chk({tag, "_idle_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_idle_hold"}, 32'(instr), 32'(exp_instr));
  endtask

  // Load byte_q (len words) with `gap` idle cycles before each byte; optionally poke fetch/load_start while idle.
  task automatic do_load(input int len, input int gap, input logic poke);
    load_len   = 9'(len);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_enter_ld_ready", 32'(ld_ready), 32'd1);
    chk("load_enter_busy", 32'(busy), 32'd1);
    chk("load_enter_fetch_ready", 32'(fetch_ready), 32'd0);
    for (int i = 0; i < len * 2; i++) begin
      for (int g = 0; g < gap; g++) begin
        fetch_req  = poke;
        fetch_addr = 8'($urandom);
        load_start = poke;
        load_len   = 9'd300;
        tick();
        fetch_req  = 1'b0;
        load_start = 1'b0;
        chk("gap_busy", 32'(busy), 32'd1);
        chk("gap_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("gap_instr_valid", 32'(instr_valid), 32'd0);
        chk("gap_instr_hold", 32'(instr), 32'(exp_instr));
        chk("gap_ld_done", 32'(ld_done), 32'd0);
        chk("gap_load_err", 32'(load_err), 32'd0);
      end
      ld_valid = 1'b1;
      ld_byte  = byte_q[i];
      tick();
      ld_valid = 1'b0;
      if (i < len * 2 - 1) begin
        chk("load_mid_busy", 32'(busy), 32'd1);
        chk("load_mid_ld_done", 32'(ld_done), 32'd0);
      end
    end
    chk("load_done_pulse", 32'(ld_done), 32'd1);
    chk("load_done_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("load_done_busy", 32'(busy), 32'd0);
    for (int w = 0; w < len; w++) model[w] = {byte_q[2*w], byte_q[2*w+1]};
    tick();
    chk("load_done_pulse_end", 32'(ld_done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0; load_len = '0;
    ld_valid = 1'b0; ld_byte = '0;
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;
    exp_instr = 16'h0000;

    // Reset state.
    tick(); tick(); tick();
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_ld_done", 32'(ld_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Clear sequence: 256 cycles not ready, then RUN.
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      chk("clear_fetch_ready", 32'(fetch_ready), 32'd0);
      tick();
    end
    chk("run_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("run_busy", 32'(busy), 32'd0);
    addr_q = '{8'h00, 8'hFF};
    fetch_burst("fetch_after_clear");

    // Directed load without gaps.
    byte_q = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h05};
    do_load(3, 0, 1'b0);
    addr_q = '{8'h00, 8'h01, 8'h02};
    fetch_burst("directed_fetch");
    chk("directed_w2_const", 32'(exp_instr), 32'h0005);

    // Scramble words 0..2, then repeat the directed load with gaps and poking.
    byte_q.delete();
    for (int i = 0; i < 6; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    do_load(3, 1, 1'b0);
    byte_q = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h05};
    do_load(3, 5, 1'b1);
    addr_q = '{8'h00, 8'h01, 8'h02, 8'h03};
    fetch_burst("gapped_fetch");

    // Oversized load is rejected; a fetch in the same cycle is still served.
    load_start = 1'b1; load_len = 9'd257; fetch_req = 1'b1; fetch_addr = 8'h01;
    tick();
    load_start = 1'b0; fetch_req = 1'b0;
    exp_instr = model[1];
    chk("err_pulse", 32'(load_err), 32'd1);
    chk("err_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("err_ld_done", 32'(ld_done), 32'd0);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_same_cycle_fetch", 32'(instr), 32'(exp_instr));
    tick();
    chk("err_pulse_end", 32'(load_err), 32'd0);

    // Zero-length load.
    load_start = 1'b1; load_len = 9'd0;
    tick();
    load_start = 1'b0;
    chk("zero_ld_done", 32'(ld_done), 32'd1);
    chk("zero_load_err", 32'(load_err), 32'd0);
    chk("zero_fetch_ready", 32'(fetch_ready), 32'd1);
    tick();
    chk("zero_ld_done_end", 32'(ld_done), 32'd0);
    addr_q = '{8'h00, 8'h01, 8'h02};
    fetch_burst("after_err_zero");

    // Random loads, including a full-depth one, then random fetch bursts.
    for (int it = 0; it < 6; it++) begin
      int len;
      len = (it == 3) ? 256 : int'($urandom_range(1, 12));
      byte_q.delete();
      for (int i = 0; i < len * 2; i++) byte_q.push_back(8'($urandom_range(0, 255)));
      do_load(len, (it == 3) ? 0 : int'($urandom_range(0, 2)), it[0]);
      addr_q.delete();
      for (int i = 0; i < 12; i++) addr_q.push_back(8'($urandom_range(0, 20)));
      addr_q.push_back(8'($urandom_range(0, 255)));
      fetch_burst("random_fetch");
    end

    // Reset in the middle of a load.
    load_start = 1'b1; load_len = 9'd4;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_byte = 8'hA0 + 8'(i);
      tick();
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_ld_ready", 32'(ld_ready), 32'd0);
    chk("midrst_instr", 32'(instr), 32'd0);
    for (int i = 0; i < 256; i++) begin
      chk("midrst_clear_fetch_ready", 32'(fetch_ready), 32'd0);
      tick();
    end
    chk("midrst_run", 32'(fetch_ready), 32'd1);
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;
    addr_q.delete();
    for (int i = 0; i < 256; i++) addr_q.push_back(8'(i));
    fetch_burst("midrst_all_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
